// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_if
// Purpose  : Bundle of signals between the IF/ID register, the pipelined
//            control unit and the datapath stage registers.
// Revision : 1.0  initial release
// ============================================================================
interface ctrl_pipe_if #(
  parameter int REG_AW = 5
);
  // ID-stage instruction fields and pipeline control from upstream
  logic              id_valid;
  logic [5:0]        id_op;
  logic [5:0]        id_func;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              flush;
  logic              freeze;

  // ID-stage decode results
  logic id_stall, id_illegal, id_isJ, id_isJAL, id_isJR, id_branch;

  // EX stage
  logic              ex_valid, ex_regWrite, ex_memToReg, ex_memRead;
  logic              ex_memWrite, ex_aluSrc, ex_shift;
  logic [5:0]        ex_op, ex_func;
  logic [REG_AW-1:0] ex_dest;
  logic [1:0]        fwd_a, fwd_b;

  // MEM stage
  logic              mem_valid, mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite;
  logic [REG_AW-1:0] mem_dest;

  // WB stage
  logic              wb_valid, wb_regWrite, wb_memToReg;
  logic [REG_AW-1:0] wb_dest;

  modport master (
    output id_valid, id_op, id_func, id_rs, id_rt, id_rd, flush, freeze,
    input  id_stall, id_illegal, id_isJ, id_isJAL, id_isJR, id_branch,
    input  ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
    input  ex_aluSrc, ex_shift, ex_op, ex_func, ex_dest, fwd_a, fwd_b,
    input  mem_valid, mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite, mem_dest,
    input  wb_valid, wb_regWrite, wb_memToReg, wb_dest
  );

  modport slave (
    input  id_valid, id_op, id_func, id_rs, id_rt, id_rd, flush, freeze,
    output id_stall, id_illegal, id_isJ, id_isJAL, id_isJR, id_branch,
    output ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
    output ex_aluSrc, ex_shift, ex_op, ex_func, ex_dest, fwd_a, fwd_b,
    output mem_valid, mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite, mem_dest,
    output wb_valid, wb_regWrite, wb_memToReg, wb_dest
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM, MEM/WB
//            control registers, load-use stall, flush/freeze and EX-stage
//            forwarding selects.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe #(
  parameter int REG_AW     = 5,
  parameter bit ENABLE_EXT = 1'b1,
  parameter int LINK_REG   = 31
) (
  input wire         clk,
  input wire         rst_n,
  ctrl_pipe_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // EX bundle also carries the source registers for forwarding
  typedef struct packed {
    logic              valid, regWrite, memToReg, memRead, memWrite, aluSrc, shift;
    logic [5:0]        op, func;
    logic [REG_AW-1:0] dest, rs, rt;
  } ex_t;

  typedef struct packed {
    logic              valid, regWrite, memToReg, memRead, memWrite;
    logic [REG_AW-1:0] dest;
  } mem_t;

  typedef struct packed {
    logic              valid, regWrite, memToReg;
    logic [REG_AW-1:0] dest;
  } wb_t;

  ex_t  dec, ex_q;
  mem_t mem_q;
  wb_t  wb_q;
  logic legal, use_rs, use_rt, is_j, is_jal, is_jr, is_br, stall;
  logic [1:0] fa, fb;

  // Decode op/func into the control bundle and source-usage flags
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.op    = bus.id_op;
    dec.func  = bus.id_func;
    dec.rs    = bus.id_rs;
    dec.rt    = bus.id_rt;
    legal     = 1'b0;
    use_rs    = 1'b1;
    use_rt    = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_br     = 1'b0;
    case (bus.id_op)
      OP_RTYPE: begin
        legal        = 1'b1;
        use_rt       = 1'b1;
        dec.dest     = bus.id_rd;
        is_jr        = (bus.id_func == FN_JR);
        dec.regWrite = (bus.id_func != FN_JR);
        dec.shift    = (bus.id_func == FN_SLL) || (bus.id_func == FN_SRL) ||
                       (bus.id_func == FN_SRA);
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal        = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.dest     = bus.id_rt;
      end
      OP_SLTI, OP_SLTIU, OP_LUI: begin
        // lui has no rs operand whether or not the extension is present
        use_rs = (bus.id_op != OP_LUI);
        if (ENABLE_EXT) begin
          legal        = 1'b1;
          dec.regWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.dest     = bus.id_rt;
        end
      end
      OP_LW: begin
        legal        = 1'b1;
        dec.memRead  = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.memToReg = 1'b1;
        dec.dest     = bus.id_rt;
      end
      OP_SW: begin
        legal        = 1'b1;
        use_rt       = 1'b1;
        dec.memWrite = 1'b1;
        dec.aluSrc   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal  = 1'b1;
        use_rt = 1'b1;
        is_br  = 1'b1;
      end
      OP_J: begin
        legal  = 1'b1;
        use_rs = 1'b0;
        is_j   = 1'b1;
      end
      OP_JAL: begin
        legal        = 1'b1;
        use_rs       = 1'b0;
        is_jal       = 1'b1;
        dec.regWrite = 1'b1;
        dec.dest     = REG_AW'(LINK_REG);
      end
      default: legal = 1'b0;
    endcase
    // Writes to register 0 are discarded, so never advertise them
    if (dec.dest == '0) dec.regWrite = 1'b0;
  end

  // Load-use hazard: the load in EX targets a register the ID instruction reads
  assign stall = bus.id_valid && ex_q.valid && ex_q.memRead && (ex_q.dest != '0) &&
                 ((use_rs && (ex_q.dest == bus.id_rs)) ||
                  (use_rt && (ex_q.dest == bus.id_rt)));

  // ID/EX register: freeze holds, any kill reason inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (!bus.freeze) begin
      if (bus.flush || stall || !bus.id_valid || !legal) ex_q <= '0;
      else                                              ex_q <= dec;
    end
  end

  // EX/MEM register: shifts every unfrozen cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mem_q <= '0;
    else if (!bus.freeze) mem_q <= {ex_q.valid, ex_q.regWrite, ex_q.memToReg,
                                    ex_q.memRead, ex_q.memWrite, ex_q.dest};
  end

  // MEM/WB register: shifts every unfrozen cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           wb_q <= '0;
    else if (!bus.freeze) wb_q <= {mem_q.valid, mem_q.regWrite, mem_q.memToReg, mem_q.dest};
  end

  // Forwarding selects; a load in MEM has no data yet, so only WB can supply it
  always_comb begin
    fa = 2'd0;
    fb = 2'd0;
    if (ex_q.rs != '0) begin
      if (mem_q.valid && mem_q.regWrite && !mem_q.memRead && (mem_q.dest == ex_q.rs)) fa = 2'd1;
      else if (wb_q.valid && wb_q.regWrite && (wb_q.dest == ex_q.rs))                 fa = 2'd2;
    end
    if (ex_q.rt != '0) begin
      if (mem_q.valid && mem_q.regWrite && !mem_q.memRead && (mem_q.dest == ex_q.rt)) fb = 2'd1;
      else if (wb_q.valid && wb_q.regWrite && (wb_q.dest == ex_q.rt))                 fb = 2'd2;
    end
  end

  assign bus.id_stall    = stall;
  assign bus.id_illegal  = bus.id_valid && !legal;
  assign bus.id_isJ      = bus.id_valid && is_j;
  assign bus.id_isJAL    = bus.id_valid && is_jal;
  assign bus.id_isJR     = bus.id_valid && is_jr;
  assign bus.id_branch   = bus.id_valid && is_br;

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_regWrite = ex_q.regWrite;
  assign bus.ex_memToReg = ex_q.memToReg;
  assign bus.ex_memRead  = ex_q.memRead;
  assign bus.ex_memWrite = ex_q.memWrite;
  assign bus.ex_aluSrc   = ex_q.aluSrc;
  assign bus.ex_shift    = ex_q.shift;
  assign bus.ex_op       = ex_q.op;
  assign bus.ex_func     = ex_q.func;
  assign bus.ex_dest     = ex_q.dest;
  assign bus.fwd_a       = fa;
  assign bus.fwd_b       = fb;

  assign bus.mem_valid    = mem_q.valid;
  assign bus.mem_regWrite = mem_q.regWrite;
  assign bus.mem_memToReg = mem_q.memToReg;
  assign bus.mem_memRead  = mem_q.memRead;
  assign bus.mem_memWrite = mem_q.memWrite;
  assign bus.mem_dest     = mem_q.dest;

  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_regWrite  = wb_q.regWrite;
  assign bus.wb_memToReg  = wb_q.memToReg;
  assign bus.wb_dest      = wb_q.dest;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Scoreboard bench for ctrl_pipe with directed instruction vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.REG_AW(5)) bus ();
  ctrl_pipe_if #(.REG_AW(5)) bus0 ();

  // Second instance without the extension ops sees identical stimulus
  assign bus0.id_valid = bus.id_valid;
  assign bus0.id_op    = bus.id_op;
  assign bus0.id_func  = bus.id_func;
  assign bus0.id_rs    = bus.id_rs;
  assign bus0.id_rt    = bus.id_rt;
  assign bus0.id_rd    = bus.id_rd;
  assign bus0.flush    = bus.flush;
  assign bus0.freeze   = bus.freeze;

  ctrl_pipe #(.REG_AW(5), .ENABLE_EXT(1'b1), .LINK_REG(31)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  ctrl_pipe #(.REG_AW(5), .ENABLE_EXT(1'b0), .LINK_REG(31)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int cmp_n = 0;
  int err_n = 0;
  logic [26:0] exq[$];
  logic [6:0]  wbq[$];
  logic [26:0] ex_act;
  logic [6:0]  wb_act;
  bit held = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: each new EX / WB occupant is compared with the next expected item
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (bus.ex_valid && !held) begin
        ex_act = {bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead, bus.ex_memWrite,
                  bus.ex_aluSrc, bus.ex_shift, bus.ex_op, bus.ex_func, bus.ex_dest,
                  bus.fwd_a, bus.fwd_b};
        if (exq.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL ex_unexpected: got %0h expected nothing", ex_act);
        end else chk("ex_bundle", 32'(ex_act), 32'(exq.pop_front()));
      end
      if (bus.wb_valid && !held) begin
        wb_act = {bus.wb_regWrite, bus.wb_memToReg, bus.wb_dest};
        if (wbq.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL wb_unexpected: got %0h expected nothing", wb_act);
        end else chk("wb_bundle", 32'(wb_act), 32'(wbq.pop_front()));
      end
      held = bus.freeze;
    end
  end

  task automatic drive(input logic [5:0] op, func, input logic [4:0] rs, rt, rd);
    bus.id_valid = 1'b1;
    bus.id_op    = op;
    bus.id_func  = func;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
  endtask

  // ctl = {regWrite, memToReg, memRead, memWrite, aluSrc, shift}
  task automatic send(input logic [5:0] op, func, input logic [4:0] rs, rt, rd,
                      input bit push, input logic [5:0] ctl, input logic [4:0] dest,
                      input logic [1:0] fa, fb, input logic stall);
    @(posedge clk); #2;
    drive(op, func, rs, rt, rd);
    #1;
    chk("id_stall", 32'(bus.id_stall), 32'(stall));
    chk("id_illegal", 32'(bus.id_illegal), 32'(0));
    if (push) begin
      exq.push_back({ctl, op, func, dest, fa, fb});
      wbq.push_back({ctl[5], ctl[4], dest});
    end
  endtask

  task automatic nop();
    @(posedge clk); #2;
    bus.id_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_ctl"}, 32'({bus.ex_valid, bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead,
                               bus.ex_memWrite, bus.ex_aluSrc, bus.ex_shift}), 32'(0));
    chk({tag, "_ex_fields"}, 32'({bus.ex_op, bus.ex_func, bus.ex_dest}), 32'(0));
    chk({tag, "_mem"}, 32'({bus.mem_valid, bus.mem_regWrite, bus.mem_memToReg, bus.mem_memRead,
                            bus.mem_memWrite, bus.mem_dest}), 32'(0));
    chk({tag, "_wb"}, 32'({bus.wb_valid, bus.wb_regWrite, bus.wb_memToReg, bus.wb_dest}), 32'(0));
    chk({tag, "_fwd"}, 32'({bus.fwd_a, bus.fwd_b}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.id_valid = 1'b0; bus.id_op = '0; bus.id_func = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.flush = 1'b0; bus.freeze = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // lw $8 then dependent add: one stall, then WB forwarding on rs
    send(6'b100011, 6'b000000, 1, 8, 0, 1, 6'b111010, 8, 0, 0, 0);
    send(6'b000000, 6'b100000, 8, 10, 9, 0, 6'b000000, 0, 0, 0, 1);
    send(6'b000000, 6'b100000, 8, 10, 9, 1, 6'b100000, 9, 2, 0, 0);

    // addi $5 then sub $6,$5,$5: MEM forwarding both operands
    send(6'b001000, 6'b000000, 0, 5, 0, 1, 6'b100010, 5, 0, 0, 0);
    send(6'b000000, 6'b100010, 5, 5, 6, 1, 6'b100000, 6, 1, 1, 0);
    // addi $11, nop, sub $12,$11,$11: WB forwarding both operands
    send(6'b001000, 6'b000000, 0, 11, 0, 1, 6'b100010, 11, 0, 0, 0);
    nop();
    send(6'b000000, 6'b100010, 11, 11, 12, 1, 6'b100000, 12, 2, 2, 0);

    // jal writes $31; addi to $0 must not write
    send(6'b000011, 6'b000000, 0, 0, 0, 1, 6'b100000, 31, 0, 0, 0);
    chk("id_isJAL", 32'(bus.id_isJAL), 32'(1));
    send(6'b001000, 6'b000000, 1, 0, 0, 1, 6'b000010, 0, 0, 0, 0);
    // sw and sll
    send(6'b101011, 6'b000000, 2, 9, 0, 1, 6'b000110, 0, 0, 0, 0);
    send(6'b000000, 6'b000000, 0, 9, 13, 1, 6'b100001, 13, 0, 0, 0);
    send(6'b000000, 6'b100000, 1, 2, 14, 1, 6'b100000, 14, 0, 0, 0);

    // freeze for 3 cycles with add $14 in EX, beq waiting in ID
    @(posedge clk); #2;
    bus.freeze = 1'b1;
    drive(6'b000100, 6'b000000, 1, 14, 0);
    #1 chk("id_branch", 32'(bus.id_branch), 32'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("freeze_ex", 32'({bus.ex_valid, bus.ex_regWrite, bus.ex_dest}), 32'({1'b1, 1'b1, 5'd14}));
      chk("freeze_mem", 32'({bus.mem_valid, bus.mem_regWrite, bus.mem_dest}), 32'({1'b1, 1'b1, 5'd13}));
      chk("freeze_wb", 32'({bus.wb_valid, bus.wb_regWrite, bus.wb_dest}), 32'({1'b1, 1'b0, 5'd0}));
    end
    bus.freeze = 1'b0;
    bus.flush  = 1'b1;
    @(posedge clk); #2;
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'(0));
    chk("flush_mem", 32'({bus.mem_valid, bus.mem_dest}), 32'({1'b1, 5'd14}));

    // lui: legal with the extension, illegal without it
    send(6'b001111, 6'b000000, 0, 3, 0, 1, 6'b100010, 3, 0, 0, 0);
    chk("noext_lui_illegal", 32'(bus0.id_illegal), 32'(1));
    @(posedge clk); #2;
    drive(6'b111111, 6'b000000, 1, 2, 3);
    #1;
    chk("bad_op_illegal", 32'(bus.id_illegal), 32'(1));
    chk("noext_bad_op_illegal", 32'(bus0.id_illegal), 32'(1));
    chk("noext_lui_bubble", 32'(bus0.ex_valid), 32'(0));
    send(6'b100011, 6'b000000, 1, 8, 0, 1, 6'b111010, 8, 0, 0, 0);
    chk("bad_op_bubble", 32'(bus.ex_valid), 32'(0));

    // asynchronous reset with lw in EX and dependent add stalled in ID
    @(posedge clk); #2;
    drive(6'b000000, 6'b100000, 8, 10, 9);
    #1 chk("pre_reset_stall", 32'(bus.id_stall), 32'(1));
    #1;
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    exq.delete();
    wbq.delete();
    #1;
    chk_all_zero("async_reset");
    chk("reset_stall", 32'(bus.id_stall), 32'(0));
    @(posedge clk); #2 rst_n = 1'b1;

    // restart: ori then jr
    send(6'b001101, 6'b000000, 1, 4, 0, 1, 6'b100010, 4, 0, 0, 0);
    send(6'b000000, 6'b001000, 31, 0, 0, 1, 6'b000000, 0, 0, 0, 0);
    chk("id_isJR", 32'(bus.id_isJR), 32'(1));
    repeat (5) nop();
    @(posedge clk); #3;
    chk("ex_queue_drained", 32'(exq.size()), 32'(0));
    chk("wb_queue_drained", 32'(wbq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
`default_nettype wire
